// File: rtl/dmem_bus_if.sv
// Data-memory bus interface: turns one pipeline load/store into a single
// handshaked bus cycle (IDLE -> BUS -> DONE), with alignment checks and a bus timeout.
module dmem_bus_if #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [2:0]           req_funct3,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 stall,
  output logic                 done,
  output logic                 err,
  output logic [BIT_WIDTH-1:0] rdata,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  input  logic                 ACKD_n,
  inout  wire  [BIT_WIDTH-1:0] DDT
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic                 r_we;
  logic [2:0]           r_funct3;
  logic [BIT_WIDTH-1:0] r_wdata;
  logic [BIT_WIDTH-1:0] r_dad;
  logic                 r_mreq;
  logic                 r_bus_write;
  logic [1:0]           r_size;
  logic                 r_err;
  logic [BIT_WIDTH-1:0] r_rdata;
  logic [WAIT_W-1:0]    r_wait;

  logic                 w_bad;
  logic                 w_ack;
  logic                 w_timeout;
  logic [WAIT_W-1:0]    w_wait_inc;
  logic                 w_ddt_oe;
  logic [BIT_WIDTH-1:0] w_store_data;

  function automatic logic f_bad_req(input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'b011, 3'b110, 3'b111: bad = 1'b1;
      3'b001, 3'b101:         bad = a[0];
      3'b010:                 bad = (a != 2'b00);
      default:                bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [1:0] f_size(input logic [1:0] f);
    logic [1:0] s;
    case (f)
      2'b00:   s = 2'b10;
      2'b01:   s = 2'b01;
      default: s = 2'b00;
    endcase
    return s;
  endfunction

  function automatic logic [BIT_WIDTH-1:0] f_store_align(input logic [1:0] f,
                                                         input logic [BIT_WIDTH-1:0] d);
    logic [BIT_WIDTH-1:0] v;
    case (f)
      2'b00:   v = {{(BIT_WIDTH-8){1'b0}}, d[7:0]};
      2'b01:   v = {{(BIT_WIDTH-16){1'b0}}, d[15:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic logic [BIT_WIDTH-1:0] f_load_ext(input logic [2:0] f3,
                                                      input logic [BIT_WIDTH-1:0] d);
    logic [BIT_WIDTH-1:0] v;
    case (f3)
      3'b000:  v = {{(BIT_WIDTH-8){d[7]}}, d[7:0]};
      3'b100:  v = {{(BIT_WIDTH-8){1'b0}}, d[7:0]};
      3'b001:  v = {{(BIT_WIDTH-16){d[15]}}, d[15:0]};
      3'b101:  v = {{(BIT_WIDTH-16){1'b0}}, d[15:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  assign w_bad        = f_bad_req(req_funct3, req_addr[1:0]);
  // Acknowledge only counts while a bus cycle is actually open.
  assign w_ack        = (r_state == S_BUS) && !ACKD_n;
  assign w_wait_inc   = r_wait + 1'b1;
  assign w_timeout    = (r_state == S_BUS) && ACKD_n && (w_wait_inc == TO_VAL);
  assign w_store_data = f_store_align(r_funct3[1:0], r_wdata);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = w_bad ? S_DONE : S_BUS;
      S_BUS:  if (w_ack || w_timeout) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    done     = (r_state == S_DONE);
    stall    = req_valid && (r_state != S_DONE);
    w_ddt_oe = (r_state == S_BUS) && r_bus_write;
  end

  assign DDT   = w_ddt_oe ? w_store_data : {BIT_WIDTH{1'bz}};
  assign DAD   = r_dad;
  assign MREQ  = r_mreq;
  assign WRITE = r_bus_write;
  assign SIZE  = r_size;
  assign err   = r_err;
  assign rdata = r_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_wdata     <= '0;
      r_dad       <= '0;
      r_mreq      <= 1'b0;
      r_bus_write <= 1'b0;
      r_size      <= 2'b00;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_wait      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_write;
            r_funct3 <= req_funct3;
            r_wdata  <= req_wdata;
            if (w_bad) begin
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else begin
              r_dad       <= req_addr;
              r_mreq      <= 1'b1;
              r_bus_write <= req_write;
              r_size      <= f_size(req_funct3[1:0]);
              r_wait      <= '0;
            end
          end
        end
        S_BUS: begin
          // Acknowledge wins over a timeout landing on the same edge.
          if (w_ack) begin
            r_mreq      <= 1'b0;
            r_bus_write <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= r_we ? '0 : f_load_ext(r_funct3, DDT);
          end else if (w_timeout) begin
            r_mreq      <= 1'b0;
            r_bus_write <= 1'b0;
            r_err       <= 1'b1;
            r_rdata     <= '0;
          end else begin
            r_wait <= w_wait_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Bench for dmem_bus_if: directed scenarios plus randomized loads/stores
// against a transaction-level model of the bus interface.
module tb_dmem_bus_if;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall, done, err;
  logic [31:0] rdata, DAD;
  logic        MREQ, WRITE;
  logic [1:0]  SIZE;
  logic        ACKD_n;
  wire  [31:0] DDT;
  logic        tb_oe;
  logic [31:0] tb_ddt;

  int n_chk  = 0;
  int n_fail = 0;

  assign DDT = tb_oe ? tb_ddt : 32'bz;

  always #5 clk = ~clk;

  dmem_bus_if #(.BIT_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .err(err), .rdata(rdata), .DAD(DAD),
    .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .ACKD_n(ACKD_n), .DDT(DDT)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit ref_bad(input int unsigned f3, input int unsigned a);
    if (f3 == 3 || f3 >= 6) return 1'b1;
    if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 2 && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_size(input int unsigned f3);
    case (f3 % 4)
      0:       return 32'd2;
      1:       return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input int unsigned f3, input int unsigned wd);
    case (f3 % 4)
      0:       return wd % 256;
      1:       return wd % 65536;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] ref_rdata(input bit w, input int unsigned f3,
                                            input int unsigned d);
    int unsigned b, h;
    b = d % 256;
    h = d % 65536;
    if (w) return 32'd0;
    case (f3)
      0:       return (b >= 128) ? b - 256 : b;
      4:       return b;
      1:       return (h >= 32768) ? h - 65536 : h;
      5:       return h;
      default: return d;
    endcase
  endfunction

  // Called at a falling edge with the DUT in IDLE; returns at a falling edge in IDLE.
  task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int lat, input logic [31:0] bd);
    bit          bad;
    bit          exp_err;
    logic [31:0] exp_rd;
    int          k;
    bad        = ref_bad(f3, a);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    ACKD_n     = 1'($urandom_range(0, 1));
    tb_oe      = 1'b0;
    #1 chk("stall_idle", 32'(stall), 32'd1);
    @(negedge clk);
    exp_err = 1'b1;
    exp_rd  = 32'd0;
    if (!bad) begin
      k = 0;
      while (1) begin
        chk("bus_mreq", 32'(MREQ), 32'd1);
        chk("bus_dad", DAD, a);
        chk("bus_size", 32'(SIZE), ref_size(f3));
        chk("bus_write", 32'(WRITE), 32'(w));
        chk("bus_done", 32'(done), 32'd0);
        chk("bus_stall", 32'(stall), 32'd1);
        if (w) chk("bus_ddt", DDT, ref_store(f3, wd));
        if (k == lat) begin
          ACKD_n  = 1'b0;
          tb_oe   = !w;
          tb_ddt  = bd;
          exp_err = 1'b0;
          exp_rd  = ref_rdata(w, f3, bd);
        end else begin
          ACKD_n = 1'b1;
          tb_oe  = 1'b0;
        end
        @(negedge clk);
        if (k == lat) break;
        if (k + 1 == TO) break;
        k++;
      end
    end
    tb_oe  = 1'b0;
    ACKD_n = 1'($urandom_range(0, 1));
    #1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_err", 32'(err), 32'(exp_err));
    chk("done_rdata", rdata, exp_rd);
    chk("done_mreq", 32'(MREQ), 32'd0);
    chk("done_write", 32'(WRITE), 32'd0);
    chk("done_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_mreq", 32'(MREQ), 32'd0);
    chk("hold_err", 32'(err), 32'(exp_err));
    chk("hold_rdata", rdata, exp_rd);
    req_valid = 1'b0;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    rst = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h8000_0010; req_wdata = 32'h0; ACKD_n = 1'b0;
    tb_oe = 1'b0; tb_ddt = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_mreq", 32'(MREQ), 32'd0);
    chk("rst_write", 32'(WRITE), 32'd0);
    chk("rst_size", 32'(SIZE), 32'd0);
    chk("rst_dad", DAD, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    req_valid = 1'b0;
    ACKD_n    = 1'b1;
    rst       = 1'b1;

    // Directed scenarios
    do_req(1'b0, 3'b010, 32'h8000_0010, 32'h0, 0, 32'hDEADBEEF);
    do_req(1'b0, 3'b000, 32'h8000_0003, 32'h0, 0, 32'h0000_0080);
    do_req(1'b0, 3'b100, 32'h8000_0003, 32'h0, 0, 32'h0000_0080);
    do_req(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 1, 32'h0);
    do_req(1'b0, 3'b010, 32'h8000_0001, 32'h0, 0, 32'h0);
    do_req(1'b0, 3'b001, 32'h8000_0002, 32'h0, 20, 32'hFFFF_8001);
    do_req(1'b0, 3'b101, 32'h8000_0006, 32'h0, TO - 1, 32'hFFFF_8001);

    // Acknowledge held low with no request: nothing must complete
    ACKD_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_ack_done", 32'(done), 32'd0);
      chk("idle_ack_mreq", 32'(MREQ), 32'd0);
    end

    // Reset during the bus phase of a byte store abandons it
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h8000_0005; req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("sb_bus_mreq", 32'(MREQ), 32'd1);
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_bus_mreq", 32'(MREQ), 32'd0);
    chk("rst_bus_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("rst_bus_done2", 32'(done), 32'd0);
    rst    = 1'b1;
    ACKD_n = 1'b1;
    do_req(1'b0, 3'b010, 32'h0000_0040, 32'h0, 0, 32'h0BAD_F00D);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_req(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom_range(0, 5), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
